// File: rtl/sccb_reg_reader.sv
// SCCB register read-back engine: writes the sub-address, restarts, then reads one byte.
// All bus activity advances on i_enable quarter-bit ticks; each bit cell is four ticks.
module sccb_reg_reader #(
    parameter logic [7:0] DEVICE_ID = 8'h42
) (
    input  logic       clk,
    input  logic       i_reset,
    input  logic       i_enable,
    input  logic       i_start,
    input  logic [7:0] i_addr,
    input  logic       i_siod,
    output logic       o_sioc,
    output logic       o_siod_oe,
    output logic [7:0] o_data,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_nack
);

    typedef enum logic [3:0] {
        StIdle, StStart1, StTxIdW, StTxSub, StStop1, StGap,
        StStart2, StTxIdR, StRxData, StStop2, StDone
    } state_e;

    state_e     state;
    state_e     next_state;
    logic [1:0] quarter;
    logic [3:0] bit_cnt;
    logic [7:0] addr_q;
    logic [7:0] shift_q;
    logic       nack_acc;
    logic [7:0] tx_byte;
    logic       ack_slot;
    logic       bit_state;

    assign ack_slot = (bit_cnt == 4'd8);

    always_comb begin
        tx_byte    = DEVICE_ID;
        bit_state  = 1'b0;
        next_state = StIdle;
        case (state)
            StStart1: next_state = StTxIdW;
            StTxIdW:  begin next_state = StTxSub;  bit_state = 1'b1; end
            StTxSub:  begin next_state = StStop1;  bit_state = 1'b1; tx_byte = addr_q; end
            StStop1:  next_state = StGap;
            StGap:    next_state = StStart2;
            StStart2: next_state = StTxIdR;
            StTxIdR:  begin
                next_state = StRxData;
                bit_state  = 1'b1;
                tx_byte    = DEVICE_ID | 8'h01;
            end
            StRxData: begin next_state = StStop2;  bit_state = 1'b1; end
            StStop2:  next_state = StDone;
            default:  next_state = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state     <= StIdle;
            quarter   <= 2'd0;
            bit_cnt   <= 4'd0;
            addr_q    <= 8'h00;
            shift_q   <= 8'h00;
            nack_acc  <= 1'b0;
            o_sioc    <= 1'b1;
            o_siod_oe <= 1'b0;
            o_data    <= 8'h00;
            o_valid   <= 1'b0;
            o_busy    <= 1'b0;
            o_nack    <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            case (state)
                StIdle: begin
                    // A request coinciding with the completion pulse is dropped.
                    if (i_start && !o_valid) begin
                        state    <= StStart1;
                        addr_q   <= i_addr;
                        shift_q  <= 8'h00;
                        nack_acc <= 1'b0;
                        quarter  <= 2'd0;
                        bit_cnt  <= 4'd0;
                        o_busy   <= 1'b1;
                    end
                end
                StDone: begin
                    o_data  <= shift_q;
                    o_nack  <= nack_acc;
                    o_valid <= 1'b1;
                    o_busy  <= 1'b0;
                    state   <= StIdle;
                end
                default: begin
                    if (i_enable) begin
                        quarter <= quarter + 2'd1;
                        case (state)
                            StStart1, StStart2: begin
                                o_sioc    <= (quarter != 2'd3);
                                o_siod_oe <= quarter[1];
                            end
                            StTxIdW, StTxSub, StTxIdR: begin
                                o_sioc <= quarter[1];
                                if (quarter == 2'd0) begin
                                    o_siod_oe <= !ack_slot && !tx_byte[3'd7 - bit_cnt[2:0]];
                                end
                                if (quarter == 2'd2 && ack_slot) begin
                                    nack_acc <= nack_acc | i_siod;
                                end
                            end
                            StRxData: begin
                                o_sioc <= quarter[1];
                                if (quarter == 2'd0) begin
                                    o_siod_oe <= 1'b0;
                                end
                                if (quarter == 2'd2 && !ack_slot) begin
                                    shift_q <= {shift_q[6:0], i_siod};
                                end
                            end
                            StStop1, StStop2: begin
                                o_sioc    <= (quarter != 2'd0);
                                o_siod_oe <= !quarter[1];
                            end
                            default: begin
                                o_sioc    <= 1'b1;
                                o_siod_oe <= 1'b0;
                            end
                        endcase
                        if (quarter == 2'd3) begin
                            if (bit_state && !ack_slot) begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end else begin
                                bit_cnt <= 4'd0;
                                state   <= next_state;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sccb_reg_reader.sv
// Bench for sccb_reg_reader: a clock-sampled SCCB slave model plus table-driven reads
// and hand-written sequences for busy rejection, completion-cycle requests and reset.
module tb_sccb_reg_reader;

    logic       clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_enable = 1'b0;
    logic       i_start = 1'b0;
    logic [7:0] i_addr = 8'h00;
    logic       i_siod;
    logic       o_sioc;
    logic       o_siod_oe;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_busy;
    logic       o_nack;

    sccb_reg_reader #(.DEVICE_ID(8'h42)) dut (
        .clk      (clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_start  (i_start),
        .i_addr   (i_addr),
        .i_siod   (i_siod),
        .o_sioc   (o_sioc),
        .o_siod_oe(o_siod_oe),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_busy   (o_busy),
        .o_nack   (o_nack)
    );

    always #5 clk = ~clk;

    // Slave model state
    logic [7:0] regs [256];
    bit         connected = 1'b1;
    bit         slv_active = 1'b0;
    bit         slv_low = 1'b0;
    bit         addressed = 1'b0;
    bit         rd_mode = 1'b0;
    int         bit_n = 0;
    int         byte_n = 0;
    logic [7:0] shift = 8'h00;
    logic [7:0] sub = 8'h00;
    logic [7:0] log_b [8];
    int         log_n = 0;
    int         starts = 0;
    int         stops = 0;
    int         ticks = 0;
    int         busy_clks = 0;
    int         valid_cnt = 0;
    int         en_period = 4;
    int         en_cnt = 0;
    bit         prev_sioc = 1'b1;
    bit         prev_siod = 1'b1;

    assign i_siod = ~(o_siod_oe | slv_low);

    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin : mon
        logic cur;
        cur = ~(o_siod_oe | slv_low);
        en_cnt   = (en_cnt + 1) % en_period;
        i_enable = (en_cnt == 0);
        if (o_busy) begin
            busy_clks++;
            if (i_enable) ticks++;
        end
        if (o_valid) valid_cnt++;
        if (i_reset) begin
            slv_active = 1'b0;
            slv_low    = 1'b0;
        end else if (prev_sioc && o_sioc && prev_siod && !cur) begin
            starts++;
            slv_active = 1'b1;
            bit_n      = 0;
            byte_n     = 0;
            addressed  = 1'b0;
            rd_mode    = 1'b0;
        end else if (prev_sioc && o_sioc && !prev_siod && cur) begin
            stops++;
            slv_active = 1'b0;
            slv_low    = 1'b0;
        end else if (!prev_sioc && o_sioc && slv_active) begin
            shift = {shift[6:0], cur};
            bit_n++;
            if (bit_n == 8) begin
                if (log_n < 8) log_b[log_n] = shift;
                log_n++;
                if (byte_n == 0) begin
                    addressed = (shift[7:1] == 7'h21);
                    rd_mode   = shift[0];
                end else if (byte_n == 1 && !rd_mode && addressed) begin
                    sub = shift;
                end
            end else if (bit_n == 9) begin
                bit_n = 0;
                byte_n++;
            end
        end else if (prev_sioc && !o_sioc) begin
            if (slv_active && connected && addressed) begin
                if (bit_n == 8) slv_low = !(rd_mode && byte_n != 0);
                else if (rd_mode && byte_n == 1) slv_low = !regs[sub][7 - bit_n];
                else slv_low = 1'b0;
            end else begin
                slv_low = 1'b0;
            end
        end
        prev_sioc = o_sioc;
        prev_siod = ~(o_siod_oe | slv_low);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [7:0] a);
        ticks     = 0;
        busy_clks = 0;
        valid_cnt = 0;
        starts    = 0;
        stops     = 0;
        log_n     = 0;
        for (int i = 0; i < 8; i++) log_b[i] = 8'h00;
        i_addr  = a;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!o_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, " valid seen"}, 32'(o_valid), 32'd1);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       nack;
        bit         conn;
        int         period;
    } vec_t;

    vec_t vecs [5];

    initial begin : main
        int n;
        vecs[0] = '{8'h0A, 8'h76, 1'b0, 1'b1, 4};
        vecs[1] = '{8'h0B, 8'hA5, 1'b0, 1'b1, 4};
        vecs[2] = '{8'h1C, 8'h7F, 1'b0, 1'b1, 4};
        vecs[3] = '{8'h0A, 8'hFF, 1'b1, 1'b0, 4};
        vecs[4] = '{8'h0B, 8'hA5, 1'b0, 1'b1, 1};
        for (int i = 0; i < 256; i++) regs[i] = 8'h00;
        regs[8'h0A] = 8'h76;
        regs[8'h0B] = 8'hA5;
        regs[8'h1C] = 8'h7F;

        repeat (20) @(negedge clk);
        check("reset sioc", 32'(o_sioc), 32'd1);
        check("reset siod_oe", 32'(o_siod_oe), 32'd0);
        check("reset busy", 32'(o_busy), 32'd0);
        check("reset valid", 32'(o_valid), 32'd0);
        check("reset data", 32'(o_data), 32'h00);
        i_reset = 1'b0;
        repeat (3) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            en_period = vecs[v].period;
            connected = vecs[v].conn;
            repeat (4) @(negedge clk);
            issue(vecs[v].addr);
            check($sformatf("row%0d busy after accept", v), 32'(o_busy), 32'd1);
            wait_valid($sformatf("row%0d", v));
            check($sformatf("row%0d data", v), 32'(o_data), 32'(vecs[v].data));
            check($sformatf("row%0d nack", v), 32'(o_nack), 32'(vecs[v].nack));
            check($sformatf("row%0d busy at valid", v), 32'(o_busy), 32'd0);
            check($sformatf("row%0d bus bytes", v), {log_b[0], log_b[1], log_b[2], log_b[3]},
                  {8'h42, vecs[v].addr, 8'h43, vecs[v].data});
            check($sformatf("row%0d starts/stops", v), 32'((starts << 4) | stops), 32'h22);
            if (vecs[v].period == 1)
                check($sformatf("row%0d busy clks", v), 32'(busy_clks), 32'd165);
            else
                check($sformatf("row%0d ticks", v), 32'(ticks), 32'd164);
            repeat (5) @(negedge clk);
            check($sformatf("row%0d single valid", v), 32'(valid_cnt), 32'd1);
        end

        en_period = 4;
        connected = 1'b1;

        // Busy rejection: a second request 10 ticks into a read is ignored.
        repeat (4) @(negedge clk);
        issue(8'h0A);
        n = 0;
        while (ticks < 10 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        i_addr  = 8'h0B;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        wait_valid("busy-reject");
        check("busy-reject data", 32'(o_data), 32'h76);
        check("busy-reject sub byte", 32'(log_b[1]), 32'h0A);
        repeat (300) @(negedge clk);
        check("busy-reject valid count", 32'(valid_cnt), 32'd1);
        check("busy-reject idle after", 32'(o_busy), 32'd0);

        // Request in the completion cycle is dropped; one clk later it is taken.
        issue(8'h0B);
        wait_valid("valid-cycle");
        i_addr  = 8'h0A;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        check("start during valid ignored", 32'(o_busy), 32'd0);
        issue(8'h1C);
        check("start after valid accepted", 32'(o_busy), 32'd1);
        wait_valid("after-valid");
        check("after-valid data", 32'(o_data), 32'h7F);

        // Reset during RX_DATA.
        repeat (4) @(negedge clk);
        issue(8'h0A);
        n = 0;
        while (ticks < 130 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("reached rx_data", 32'(ticks >= 130), 32'd1);
        i_reset = 1'b1;
        @(negedge clk);
        check("midop reset sioc", 32'(o_sioc), 32'd1);
        check("midop reset siod_oe", 32'(o_siod_oe), 32'd0);
        check("midop reset busy", 32'(o_busy), 32'd0);
        check("midop reset data", 32'(o_data), 32'h00);
        check("midop reset nack", 32'(o_nack), 32'd0);
        @(negedge clk);
        i_reset = 1'b0;
        repeat (400) @(negedge clk);
        check("midop no valid", 32'(valid_cnt), 32'd0);
        issue(8'h0A);
        wait_valid("post-reset");
        check("post-reset data", 32'(o_data), 32'h76);
        check("post-reset nack", 32'(o_nack), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL global timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
